mem_port_arbiter: RTL and testbench

Shares the single synchronous RAM port between the core's instruction-fetch requester and its load/store requester. Arbitrates per cycle with data-side priority and a bounded-starvation guarantee for fetch, drives the RAM address/strobe/write-mask lines, and routes the one-cycle-latency read data back to the requester that issued the read. Sits between the processor's fetch/memory stages and the RAM macro.

---
 rtl/mem_port_arbiter.sv | 91 +++++++++
 tb/tb_mem_port_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between instruction fetch and load/store.
// Data side has priority; fetch is forced through after STARVE_LIMIT straight data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_wmask,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rstrb,
  output logic [3:0]        ram_wmask,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {
    RTAG_IDLE,
    RTAG_FETCH,
    RTAG_DATA
  } rtag_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  rtag_e      rtag_q, rtag_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       fetch_wins;
  logic       d_write;

  always_comb begin
    fetch_wins   = i_req && (!d_req || (starve_cnt_q == LIMIT));
    i_gnt        = fetch_wins;
    d_gnt        = d_req && !fetch_wins;
    d_write      = (d_wmask != 4'b0000);
    ram_addr     = '0;
    ram_rstrb    = 1'b0;
    ram_wmask    = 4'b0000;
    ram_wdata    = 32'h0;
    rtag_d       = RTAG_IDLE;
    starve_cnt_d = starve_cnt_q;

    if (i_gnt) begin
      ram_addr  = i_addr;
      ram_rstrb = 1'b1;
      rtag_d    = RTAG_FETCH;
    end else if (d_gnt) begin
      ram_addr = d_addr;
      if (d_write) begin
        ram_wmask = d_wmask;
        ram_wdata = d_wdata;
      end else begin
        ram_rstrb = 1'b1;
        rtag_d    = RTAG_DATA;
      end
    end

    // Count only data grants that actually make a waiting fetch wait longer.
    if (!i_req || i_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (d_gnt && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rtag_q       <= RTAG_IDLE;
      starve_cnt_q <= 4'd0;
    end else begin
      rtag_q       <= rtag_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign i_rvalid = (rtag_q == RTAG_FETCH);
  assign d_rvalid = (rtag_q == RTAG_DATA);
  assign i_rdata  = ram_rdata;
  assign d_rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a reference arbiter model predicts grants and
// RAM lines each cycle and queues expected read returns, which are popped as they arrive.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req, i_gnt, i_rvalid;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_rdata;
  logic              d_req, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [3:0]        d_wmask;
  logic [31:0]       d_wdata, d_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rstrb;
  logic [3:0]        ram_wmask;
  logic [31:0]       ram_wdata, ram_rdata;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_rstrb(ram_rstrb), .ram_wmask(ram_wmask),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM macro stand-in, driven only by the DUT's RAM lines.
  logic [31:0] ram_mem [256];
  logic [31:0] ref_mem [256];

  always @(posedge clk) begin
    if (ram_rstrb) ram_rdata <= ram_mem[ram_addr[9:2]];
    for (int b = 0; b < 4; b++)
      if (ram_wmask[b]) ram_mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  typedef struct {
    logic        fetch;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cnt    = 0;
  int   txn    = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (txn %0d)", tag, act, exp, txn);
    end
  endtask

  // One clock cycle: drive requests, check grant-cycle outputs, advance the model,
  // then check the read-return side after the edge.
  task automatic step(input logic ireq, input logic [31:0] iaddr,
                      input logic dreq, input logic [31:0] daddr,
                      input logic [3:0] dmask, input logic [31:0] dwdata,
                      input logic rst_mid);
    logic        fw, eig, edg;
    logic [31:0] e_addr, e_wdata;
    logic        e_rstrb;
    logic [3:0]  e_wmask;
    exp_t        e;
    @(negedge clk);
    reset   = 1'b0;
    i_req   = ireq;  i_addr = iaddr;
    d_req   = dreq;  d_addr = daddr;  d_wmask = dmask;  d_wdata = dwdata;
    #1;
    fw  = ireq && (!dreq || cnt == LIMIT);
    eig = fw;
    edg = dreq && !fw;
    e_addr = 0; e_rstrb = 0; e_wmask = 0; e_wdata = 0;
    if (eig) begin
      e_addr = iaddr; e_rstrb = 1;
    end else if (edg) begin
      e_addr = daddr;
      if (dmask == 0) e_rstrb = 1;
      else begin e_wmask = dmask; e_wdata = dwdata; end
    end
    check_val("i_gnt", 32'(i_gnt), 32'(eig));
    check_val("d_gnt", 32'(d_gnt), 32'(edg));
    check_val("ram_addr", ram_addr, e_addr);
    check_val("ram_rstrb", 32'(ram_rstrb), 32'(e_rstrb));
    check_val("ram_wmask", 32'(ram_wmask), 32'(e_wmask));
    check_val("ram_wdata", ram_wdata, e_wdata);
    $display("txn %0d: ireq=%0b dreq=%0b mask=%h -> i_gnt=%0b d_gnt=%0b addr=%h",
             txn, ireq, dreq, dmask, i_gnt, d_gnt, ram_addr);

    if (rst_mid) begin
      #1;
      reset = 1'b1;
      i_req = 1'b0;
      d_req = 1'b0;
      #1;
      check_val("rvalid_in_reset", {i_rvalid, d_rvalid}, 32'h0);
      sb.delete();
      cnt = 0;
    end else begin
      if (eig) sb.push_back('{1'b1, ref_mem[iaddr[9:2]]});
      else if (edg) begin
        if (dmask == 0) sb.push_back('{1'b0, ref_mem[daddr[9:2]]});
        else for (int b = 0; b < 4; b++)
          if (dmask[b]) ref_mem[daddr[9:2]][8*b +: 8] = dwdata[8*b +: 8];
      end
      if (!ireq || eig) cnt = 0;
      else if (edg && cnt != LIMIT) cnt++;
    end

    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val("i_rvalid", 32'(i_rvalid), 32'(e.fetch));
      check_val("d_rvalid", 32'(d_rvalid), 32'(!e.fetch));
      check_val(e.fetch ? "i_rdata" : "d_rdata", e.fetch ? i_rdata : d_rdata, e.data);
    end else begin
      check_val("rvalid_idle", {i_rvalid, d_rvalid}, 32'h0);
    end
    txn++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 32'hC0DE0000 ^ (i * 32'h01010101);
      ref_mem[i] = 32'hC0DE0000 ^ (i * 32'h01010101);
    end
    ram_mem[8'h10] = 32'h00A00093;
    ref_mem[8'h10] = 32'h00A00093;
    reset = 1'b1;
    i_req = 0; i_addr = 0; d_req = 0; d_addr = 0; d_wmask = 0; d_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_rvalid", {i_rvalid, d_rvalid}, 32'h0);

    // Lone fetch
    step(1, 32'h40, 0, 0, 4'h0, 0, 0);
    // Collision: data wins, fetch follows
    step(1, 32'h44, 1, 32'h100, 4'h0, 0, 0);
    step(1, 32'h44, 0, 0, 4'h0, 0, 0);
    step(0, 0, 0, 0, 4'h0, 0, 0);
    // Write with no return, then read back
    step(0, 0, 1, 32'h203, 4'b1000, 32'h7F000000, 0);
    step(0, 0, 1, 32'h200, 4'h0, 0, 0);
    step(0, 0, 0, 0, 4'h0, 0, 0);
    // Starvation: four data grants, one fetch, data resumes
    for (int k = 0; k < 7; k++) step(1, 32'h80, 1, 32'h104 + 4 * k, 4'h0, 0, 0);
    // Back-to-back fetch then data read
    step(1, 32'h48, 0, 0, 4'h0, 0, 0);
    step(0, 0, 1, 32'h108, 4'h0, 0, 0);
    step(0, 0, 0, 0, 4'h0, 0, 0);
    // Random mix
    for (int k = 0; k < 60; k++) begin
      logic [3:0] m;
      m = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      step(1'($urandom_range(0, 1)), {22'h0, 8'($urandom), 2'b00},
           1'($urandom_range(0, 1)), {22'h0, 10'($urandom)}, m, $urandom, 0);
    end
    // Reset mid-read after building up the starvation count
    step(1, 32'h4C, 1, 32'h10C, 4'h0, 0, 0);
    step(1, 32'h4C, 1, 32'h110, 4'h0, 0, 0);
    step(1, 32'h4C, 1, 32'h114, 4'h0, 0, 1);
    for (int k = 0; k < 6; k++) step(1, 32'h4C, 1, 32'h118, 4'h0, 0, 0);
    step(0, 0, 0, 0, 4'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
